// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO.
// Frames are start + DATA_WIDTH data bits (LSB first) + stop. Defining the
// macro UART_RX_PARITY_EN adds one even-parity bit between data and stop.
// A good frame is pushed into the FIFO at the stop-bit sample; a bad stop or
// parity bit produces a one-cycle rx_frame_err pulse instead, and a good frame
// arriving while the FIFO is full (with no pop that cycle) produces a
// one-cycle rx_overflow pulse.
module uart_rx_fifo #(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  rx_rdy,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_data_vld,
  output logic                  rx_frame_err,
  output logic                  rx_overflow
);

  localparam int BIT_CYC  = CLK_FREQUENCE / BAUD_RATE;
  localparam int HALF_CYC = (BIT_CYC / 2 > 0) ? BIT_CYC / 2 : 1;
  localparam int CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int BIT_W    = $clog2(DATA_WIDTH + 1);
  localparam int ADDR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W    = ADDR_W + 1;

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic                  rx_meta;
  logic                  rx_sync;
  logic                  rx_prev;
  logic [1:0]            sync_fill;
  logic                  armed;

  logic [CNT_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;

  logic                  cnt_clr;
  logic                  shift_en;
  logic                  push_req;
  logic                  frame_bad;
  logic                  frame_ok;

`ifdef UART_RX_PARITY_EN
  logic                  par_sample;
  logic                  par_err;
`endif

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [OCC_W-1:0]      count;
  logic [DATA_WIDTH-1:0] last_word;
  logic                  full;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;

  // Two-flop synchronizer plus edge-detect history. Start edges are only
  // accepted once the line has been seen high with real (post-reset) samples.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_sync) begin
        armed <= 1'b1;
      end
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign frame_ok = rx_sync && !par_err;
`else
  assign frame_ok = rx_sync;
`endif

  // Next-state logic and per-cycle control strobes for the datapath.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    push_req   = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (armed && rx_prev && !rx_sync) begin
          next_state = START;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          cnt_clr    = 1'b1;
          next_state = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == FULL_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_cnt == FULL_LAST) begin
          cnt_clr    = 1'b1;
          par_sample = 1'b1;
          next_state = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_cnt == FULL_LAST) begin
          cnt_clr    = 1'b1;
          next_state = IDLE;
          if (frame_ok) begin
            push_req = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Baud counter, data bit counter and LSB-first shift register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      baud_cnt <= cnt_clr ? '0 : baud_cnt + 1'b1;
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        shift_reg <= {rx_sync, shift_reg[DATA_WIDTH-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even-parity check: data bits plus the parity bit must hold an even count of ones.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (state == START) begin
      par_err <= 1'b0;
    end else if (par_sample) begin
      par_err <= ^{shift_reg, rx_sync};
    end
  end
`endif

  assign rx_data_vld = (count != '0);
  assign full        = (count == DEPTH_OCC);
  assign pop         = rx_data_vld && rx_rdy;
  assign wr_en       = push_req && (!full || pop);
  assign drop        = push_req && full && !pop;
  assign rx_data_out = rx_data_vld ? mem[rd_ptr] : last_word;

  // FIFO storage; a write while full is only allowed when the head leaves in the same cycle.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  // FIFO pointers, occupancy, and the word shown on the output while empty.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_word <= mem[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // One-cycle status pulses for rejected and dropped frames.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_frame_err <= 1'b0;
      rx_overflow  <= 1'b0;
    end else begin
      rx_frame_err <= frame_bad;
      rx_overflow  <= drop;
    end
  end

endmodule
